// File: rtl/axi_aw_arbiter.sv
// axi_aw_arbiter: round-robin sharing of one AXI AW channel among NUM_REQ requesters
// with a registered downstream slot, source-tagged IDs and an outstanding-write cap.
module axi_aw_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = 4,
  parameter int ADDR_W          = 32,
  parameter int LEN_W           = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int SRC_W           = $clog2(NUM_REQ),
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_awvalid,
  output logic [NUM_REQ-1:0]        req_awready,
  input  logic [NUM_REQ*ID_W-1:0]   req_awid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_awaddr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_awlen,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [ID_W+SRC_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]         m_awaddr,
  output logic [LEN_W-1:0]          m_awlen,
  input  logic                      b_done,
  output logic [CNT_W-1:0]          outstanding,
  output logic [SRC_W-1:0]          grant_idx,
  output logic                      err_underflow
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                 r_state, w_next;
  logic [SRC_W-1:0]       r_last;
  logic [ID_W+SRC_W-1:0]  r_id;
  logic [ADDR_W-1:0]      r_addr;
  logic [LEN_W-1:0]       r_len;
  logic [CNT_W-1:0]       r_out;
  logic                   r_err;
  logic [SRC_W-1:0]       w_winner, w_cand;
  logic                   w_found, w_grant, w_hs;
  logic [ID_W-1:0]        w_id   [NUM_REQ];
  logic [ADDR_W-1:0]      w_addr [NUM_REQ];
  logic [LEN_W-1:0]       w_len  [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_id[g]   = req_awid[g*ID_W +: ID_W];
    assign w_addr[g] = req_awaddr[g*ADDR_W +: ADDR_W];
    assign w_len[g]  = req_awlen[g*LEN_W +: LEN_W];
  end
  // Scan from farthest to nearest so the nearest valid requester after r_last wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = SRC_W'((int'(r_last) + k) % NUM_REQ);
      if (req_awvalid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end
  assign w_grant = (r_state == IDLE) && (r_out < CNT_W'(MAX_OUTSTANDING)) && w_found;
  assign w_hs    = (r_state == BUSY) && m_awready;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb w_next = w_grant ? BUSY : w_hs ? IDLE : r_state;
  always_comb req_awready = w_grant ? NUM_REQ'(1) << w_winner : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id   <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_last <= SRC_W'(NUM_REQ - 1);
    end else if (w_grant) begin
      r_id   <= {w_winner, w_id[w_winner]};
      r_addr <= w_addr[w_winner];
      r_len  <= w_len[w_winner];
      r_last <= w_winner;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_err <= 1'b0;
    end else if (w_hs && !b_done) begin
      r_out <= r_out + CNT_W'(1);
    end else if (!w_hs && b_done) begin
      if (r_out == '0) r_err <= 1'b1;
      else r_out <= r_out - CNT_W'(1);
    end
  end
  assign m_awvalid     = (r_state == BUSY);
  assign m_awid        = r_id;
  assign m_awaddr      = r_addr;
  assign m_awlen       = r_len;
  assign outstanding   = r_out;
  assign grant_idx     = r_last;
  assign err_underflow = r_err;
endmodule

// File: tb/tb_axi_aw_arbiter.sv
// tb_axi_aw_arbiter: directed stimulus against a cycle-level behavioural model plus literal spot checks.
module tb_axi_aw_arbiter;
  localparam int N = 4, IW = 4, AW = 32, LW = 8, MAXO = 2, SW = 2, CW = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] req_awvalid = '0, req_awready;
  logic [IW-1:0] ids [N];
  logic [AW-1:0] addrs [N];
  logic [LW-1:0] lens [N];
  logic [N*IW-1:0] req_awid;
  logic [N*AW-1:0] req_awaddr;
  logic [N*LW-1:0] req_awlen;
  logic m_awvalid, m_awready = 1'b0, b_done = 1'b0, err_underflow;
  logic [IW+SW-1:0] m_awid;
  logic [AW-1:0] m_awaddr;
  logic [LW-1:0] m_awlen;
  logic [CW-1:0] outstanding;
  logic [SW-1:0] grant_idx;
  int errors = 0, checks = 0;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_awid[g*IW +: IW]   = ids[g];
    assign req_awaddr[g*AW +: AW] = addrs[g];
    assign req_awlen[g*LW +: LW]  = lens[g];
  end
  axi_aw_arbiter #(.NUM_REQ(N), .ID_W(IW), .ADDR_W(AW), .LEN_W(LW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .req_awvalid(req_awvalid), .req_awready(req_awready),
    .req_awid(req_awid), .req_awaddr(req_awaddr), .req_awlen(req_awlen),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .b_done(b_done), .outstanding(outstanding), .grant_idx(grant_idx),
    .err_underflow(err_underflow));
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int arb(input logic [N-1:0] v, input int last);
    int r = -1;
    for (int k = 1; k <= N; k++)
      if (r < 0 && v[(last + k) % N]) r = (last + k) % N;
    return r;
  endfunction
  bit mv_ok = 0, mbusy, merr, mhs;
  int mout, mlast, mw, ew;
  logic [IW+SW-1:0] mid;
  logic [AW-1:0] maddr;
  logic [LW-1:0] mlen;
  always @(posedge clk) begin
    if (rst) begin
      mv_ok = 1; mbusy = 0; mout = 0; merr = 0; mlast = N - 1; mid = '0; maddr = '0; mlen = '0;
    end else if (mv_ok) begin
      mhs = mbusy && m_awready;
      mw = (!mbusy && mout < MAXO) ? arb(req_awvalid, mlast) : -1;
      if (mhs && !b_done) mout++;
      else if (b_done && !mhs) begin
        if (mout == 0) merr = 1;
        else mout--;
      end
      if (mw >= 0) begin
        mbusy = 1; mlast = mw;
        mid = (IW+SW)'(mw * (1 << IW) + int'(ids[mw]));
        maddr = addrs[mw]; mlen = lens[mw];
      end else if (mhs) mbusy = 0;
    end
  end
  always @(negedge clk) begin
    if (mv_ok) begin
      ew = (!mbusy && mout < MAXO) ? arb(req_awvalid, mlast) : -1;
      check("req_awready", 64'(req_awready), ew >= 0 ? 64'(1) << ew : 64'(0));
      check("m_awvalid", 64'(m_awvalid), 64'(mbusy));
      if (mbusy) begin
        check("m_awid", 64'(m_awid), 64'(mid));
        check("m_awaddr", 64'(m_awaddr), 64'(maddr));
        check("m_awlen", 64'(m_awlen), 64'(mlen));
      end
      check("outstanding", 64'(outstanding), 64'(mout));
      check("grant_idx", 64'(grant_idx), 64'(mlast));
      check("err_underflow", 64'(err_underflow), 64'(merr));
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  int order [6];
  int exp_order [6] = '{0, 1, 2, 3, 0, 1};
  initial begin
    for (int i = 0; i < N; i++) begin
      ids[i] = IW'(3 + i); addrs[i] = AW'(32'h1000 * (i + 1)); lens[i] = LW'(7 + i);
    end
    cyc(2); rst = 0;
    check("rst_valid", 64'(m_awvalid), 0);
    check("rst_out", 64'(outstanding), 0);
    check("rst_gidx", 64'(grant_idx), 3);
    check("rst_err", 64'(err_underflow), 0);
    check("rst_id", 64'(m_awid), 0);
    req_awvalid = 4'b0001; m_awready = 1; #1;
    check("t1_ready", 64'(req_awready), 64'b0001);
    cyc(1);
    check("t1_valid", 64'(m_awvalid), 1);
    check("t1_id", 64'(m_awid), 64'h03);
    check("t1_addr", 64'(m_awaddr), 64'h1000);
    check("t1_len", 64'(m_awlen), 7);
    req_awvalid = 0; cyc(1);
    check("t1_out", 64'(outstanding), 1);
    b_done = 1; cyc(1); b_done = 0;
    check("t1_drain", 64'(outstanding), 0);
    rst = 1; cyc(1); rst = 0;
    req_awvalid = 4'hF;
    for (int g = 0; g < 6; g++) begin
      cyc(1); order[g] = int'(grant_idx);
      check("rr_valid", 64'(m_awvalid), 1);
      b_done = 1; cyc(1); b_done = 0;
    end
    for (int g = 0; g < 6; g++) check("rr_order", 64'(order[g]), 64'(exp_order[g]));
    req_awvalid = 0;
    m_awready = 0; req_awvalid = 4'b0100; cyc(1);
    check("bp_id", 64'(m_awid), 64'h25);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("bp_valid", 64'(m_awvalid), 1);
      check("bp_addr", 64'(m_awaddr), 64'h3000);
      check("bp_ready", 64'(req_awready), 0);
    end
    m_awready = 1; req_awvalid = 0; cyc(1);
    check("bp_hs", 64'(m_awvalid), 0);
    check("bp_out", 64'(outstanding), 1);
    req_awvalid = 4'b0010; cyc(1); req_awvalid = 0;
    b_done = 1; cyc(1); b_done = 0;
    check("same_out", 64'(outstanding), 1);
    check("same_err", 64'(err_underflow), 0);
    b_done = 1; cyc(1); b_done = 0;
    req_awvalid = 4'b0010; cyc(6);
    check("max_out", 64'(outstanding), 2);
    check("max_stall", 64'(m_awvalid), 0);
    check("max_ready", 64'(req_awready), 0);
    b_done = 1; cyc(1); b_done = 0;
    check("max_dec", 64'(outstanding), 1);
    check("max_regrant", 64'(req_awready), 64'b0010);
    cyc(2);
    check("max_out2", 64'(outstanding), 2);
    req_awvalid = 0;
    b_done = 1; cyc(2);
    check("uf_zero", 64'(outstanding), 0);
    check("uf_noerr", 64'(err_underflow), 0);
    cyc(1); b_done = 0;
    check("uf_err", 64'(err_underflow), 1);
    check("uf_out", 64'(outstanding), 0);
    cyc(3);
    check("uf_sticky", 64'(err_underflow), 1);
    m_awready = 0; req_awvalid = 4'b1000; cyc(1);
    check("rb_valid", 64'(m_awvalid), 1);
    check("rb_gidx", 64'(grant_idx), 3);
    rst = 1; cyc(1); rst = 0; req_awvalid = 4'hF;
    check("rb_drop", 64'(m_awvalid), 0);
    check("rb_out", 64'(outstanding), 0);
    check("rb_err", 64'(err_underflow), 0);
    #1 check("rb_ready", 64'(req_awready), 64'b0001);
    cyc(1);
    check("rb_gidx0", 64'(grant_idx), 0);
    check("rb_id", 64'(m_awid), 64'h03);
    m_awready = 1; req_awvalid = 0; cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
